apb3_timer_slave: RTL

APB3_TIMER_SLAVE -- requirements
Module: apb3_timer_slave

---
 rtl/apb3_timer_pkg.sv | 37 +++
 rtl/apb3_slave_if.sv | 66 ++++++
 rtl/apb3_timer_slave.sv | 119 +++++++++++
 3 files changed

// File: rtl/apb3_timer_pkg.sv
// Shared definitions for the APB3 timer slave: register map, CTRL bit positions,
// bus FSM encoding and the address/direction legality check.
package apb3_timer_pkg;

  localparam int unsigned ADDR_W = 6;
  localparam int unsigned WAIT_W = 4;
  localparam int unsigned CTRL_W = 3;

  // Word offsets, i.e. PADDR[7:2]
  localparam logic [ADDR_W-1:0] OFS_LOAD   = 6'h00;
  localparam logic [ADDR_W-1:0] OFS_VALUE  = 6'h01;
  localparam logic [ADDR_W-1:0] OFS_CTRL   = 6'h02;
  localparam logic [ADDR_W-1:0] OFS_INTCLR = 6'h03;
  localparam logic [ADDR_W-1:0] OFS_RIS    = 6'h04;

  localparam int unsigned CTRL_EN       = 0;
  localparam int unsigned CTRL_PERIODIC = 1;
  localparam int unsigned CTRL_IRQEN    = 2;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_ACCESS = 1'b1
  } apb_state_e;

  // Unmapped offsets, writes to read-only and reads of write-only are errors.
  function automatic logic access_error(input logic [ADDR_W-1:0] addr, input logic write);
    logic err;
    case (addr)
      OFS_LOAD, OFS_CTRL:  err = 1'b0;
      OFS_VALUE, OFS_RIS:  err = write;
      OFS_INTCLR:          err = !write;
      default:             err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/apb3_slave_if.sv
// APB3 completion FSM with a programmable wait-state counter; produces the
// access (PREADY) strobe, write-commit strobe, decoded address and error flag.
module apb3_slave_if
  import apb3_timer_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic [ADDR_W-1:0] paddr,
  output logic              access,
  output logic              wr_commit,
  output logic [ADDR_W-1:0] addr,
  output logic              err
);

  localparam logic [WAIT_W-1:0] WAIT_INIT = WAIT_W'(WAIT_STATES);

  apb_state_e        state_q, state_d;
  logic [WAIT_W-1:0] wait_q, wait_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      wait_q  <= '0;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
    end
  end

  always_comb begin
    state_d = state_q;
    wait_d  = wait_q;
    access  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (psel && !penable) begin
          state_d = ST_ACCESS;
          wait_d  = WAIT_INIT;
        end
      end
      ST_ACCESS: begin
        // A master that drops PSEL abandons the transfer without completion.
        if (!psel) begin
          state_d = ST_IDLE;
          wait_d  = '0;
        end else if (wait_q != '0) begin
          wait_d = wait_q - WAIT_W'(1);
        end else if (penable) begin
          access  = 1'b1;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign addr      = paddr;
  assign err       = access && access_error(paddr, pwrite);
  assign wr_commit = access && pwrite && !err;

endmodule

// File: rtl/apb3_timer_slave.sv
// APB3 down-counting timer: LOAD/VALUE/CTRL/INTCLR/RIS registers with one-shot
// or periodic reload and a level interrupt.
module apb3_timer_slave
  import apb3_timer_pkg::*;
#(
  parameter int unsigned WAIT_STATES = 1,
  parameter logic [31:0] RST_LOAD    = 32'h0000_FFFF
) (
  input  logic        HCLK,
  input  logic        HRESETN,
  input  logic [31:0] PADDR,
  input  logic        PSEL,
  input  logic        PENABLE,
  input  logic        PWRITE,
  input  logic [31:0] PWDATA,
  output logic [31:0] PRDATA,
  output logic        PREADY,
  output logic        PSLVERR,
  output logic        IRQ
);

  logic              bus_access;
  logic              bus_wr_commit;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_err;
  logic              unused_paddr;

  logic [31:0]       load_q, load_d;
  logic [31:0]       value_q, value_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic              ris_q, ris_d;
  logic              underflow;

  assign unused_paddr = ^{PADDR[31:8], PADDR[1:0]};

  apb3_slave_if #(
    .WAIT_STATES(WAIT_STATES)
  ) u_if (
    .clk      (HCLK),
    .rst_n    (HRESETN),
    .psel     (PSEL),
    .penable  (PENABLE),
    .pwrite   (PWRITE),
    .paddr    (PADDR[7:2]),
    .access   (bus_access),
    .wr_commit(bus_wr_commit),
    .addr     (bus_addr),
    .err      (bus_err)
  );

  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      load_q  <= RST_LOAD;
      value_q <= RST_LOAD;
      ctrl_q  <= '0;
      ris_q   <= 1'b0;
    end else begin
      load_q  <= load_d;
      value_q <= value_d;
      ctrl_q  <= ctrl_d;
      ris_q   <= ris_d;
    end
  end

  assign underflow = ctrl_q[CTRL_EN] && (value_q == '0);

  always_comb begin
    load_d  = load_q;
    value_d = value_q;
    ctrl_d  = ctrl_q;
    ris_d   = ris_q;

    if (ctrl_q[CTRL_EN]) begin
      if (!underflow) begin
        value_d = value_q - 32'd1;
      end else if (ctrl_q[CTRL_PERIODIC]) begin
        value_d = load_q;
      end else begin
        ctrl_d[CTRL_EN] = 1'b0;
      end
    end

    // Bus writes come after the counter update so a LOAD/CTRL write wins.
    if (bus_wr_commit) begin
      case (bus_addr)
        OFS_LOAD: begin
          load_d  = PWDATA;
          value_d = PWDATA;
        end
        OFS_CTRL:   ctrl_d = PWDATA[CTRL_W-1:0];
        OFS_INTCLR: ris_d  = 1'b0;
        default: ;
      endcase
    end

    // Underflow is applied last so it beats a coincident INTCLR.
    if (underflow) begin
      ris_d = 1'b1;
    end
  end

  always_comb begin
    PRDATA = '0;
    if (bus_access && !PWRITE && !bus_err) begin
      case (bus_addr)
        OFS_LOAD:  PRDATA = load_q;
        OFS_VALUE: PRDATA = value_q;
        OFS_CTRL:  PRDATA = {{(32-CTRL_W){1'b0}}, ctrl_q};
        OFS_RIS:   PRDATA = {31'd0, ris_q};
        default:   PRDATA = '0;
      endcase
    end
  end

  assign PREADY  = bus_access;
  assign PSLVERR = bus_err;
  assign IRQ     = ris_q && ctrl_q[CTRL_IRQEN];

endmodule
